// File: rtl/hazard_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : hazard_pkg
//  Description : Shared types for the pipeline hazard/forwarding controller.
//                Holds the forward-select encoding, the stall FSM state type
//                and the raw select constants.
//  Revision    : 1.0  initial release
// ============================================================================
package hazard_pkg;

   // Raw EX operand-mux select codes; 2'b11 is unused.
   localparam logic [1:0] FWD_RF = 2'b00;   // register file
   localparam logic [1:0] FWD_ME = 2'b01;   // producer currently in ME
   localparam logic [1:0] FWD_WB = 2'b10;   // producer currently in WB

   typedef enum logic [1:0] {
      SEL_RF = FWD_RF,
      SEL_ME = FWD_ME,
      SEL_WB = FWD_WB
   } fwd_sel_e;

   typedef enum logic [0:0] {
      RUN   = 1'b0,
      STALL = 1'b1
   } haz_state_e;

endpackage
`default_nettype wire

// File: rtl/hazard_fwd_unit_fwd_match.sv
`default_nettype none
// ============================================================================
//  Module      : fwd_match
//  Description : Decode-time bypass match for a single source operand.
//                Compares the source index against the EX and ME destinations
//                and produces the select the operand needs once it reaches EX,
//                plus a load-use hit flag.
//  Ports       : rs, rs_used          source index / source actually read
//                rd_ex, wr_ex         EX destination / EX writes RF
//                is_load_ex           EX instruction is a load
//                rd_me, wr_me         ME destination / ME writes RF
//                sel                  next forward select for this source
//                load_hit             source depends on the load in EX
//  Revision    : 1.0  initial release
// ============================================================================
module fwd_match
   import hazard_pkg::*;
#(
   parameter int REG_AW = 5
)
(
   input  logic [REG_AW-1:0] rs,
   input  logic              rs_used,
   input  logic [REG_AW-1:0] rd_ex,
   input  logic              wr_ex,
   input  logic              is_load_ex,
   input  logic [REG_AW-1:0] rd_me,
   input  logic              wr_me,
   output fwd_sel_e          sel,
   output logic              load_hit
);

   logic w_live;
   logic w_hit_ex;
   logic w_hit_me;

   // x0 is hard-wired zero and never needs a bypass.
   assign w_live   = rs_used && (rs != '0);
   assign w_hit_ex = w_live && wr_ex && (rs == rd_ex);
   assign w_hit_me = w_live && wr_me && (rs == rd_me);

   // EX producer is the youngest, so it wins. A load in EX cannot feed the
   // consumer next cycle (load-use stall handles it), so it is skipped here.
   always_comb begin
      sel = SEL_RF;
      if (w_hit_ex && !is_load_ex) begin
         sel = SEL_ME;
      end else if (w_hit_me) begin
         sel = SEL_WB;
      end
   end

   assign load_hit = w_hit_ex && is_load_ex;

endmodule
`default_nettype wire

// File: rtl/hazard_fwd_unit.sv
`default_nettype none
// ============================================================================
//  Module      : hazard_fwd_unit
//  Description : Forwarding + hazard controller for a 5-stage pipeline.
//                Registers per-source EX bypass selects, stalls IF/DE for
//                LOAD_LAT cycles on load-use, flushes IF/DE on a taken branch
//                resolved in EX. Branch takes priority over any stall.
//  Config      : HAZ_STATS_EN  enables saturating statistics counters;
//                              otherwise stat_* are tied to zero.
//  Ports       : clk, rst_n          clock, synchronous active-low reset
//                rs_de, rs_used_de   decode sources (src i at [i*REG_AW +: REG_AW])
//                rd_ex/ruwr_ex/is_load_ex  EX destination info
//                rd_me/ruwr_me       ME destination info
//                br_taken_ex         taken branch/jump in EX
//                stall_fd, bubble_ex, flush_fd   pipeline control
//                fwd_sel_ex          registered 2-bit select per source
//                stat_stall/flush/fwd  statistics
//  Revision    : 1.0  initial release
// ============================================================================
module hazard_fwd_unit
   import hazard_pkg::*;
#(
   parameter int REG_AW   = 5,
   parameter int NUM_SRC  = 2,
   parameter int LOAD_LAT = 1,
   parameter int STAT_W   = 32
)
(
   input  logic                      clk,
   input  logic                      rst_n,
   input  logic [NUM_SRC*REG_AW-1:0] rs_de,
   input  logic [NUM_SRC-1:0]        rs_used_de,
   input  logic [REG_AW-1:0]         rd_ex,
   input  logic                      ruwr_ex,
   input  logic                      is_load_ex,
   input  logic [REG_AW-1:0]         rd_me,
   input  logic                      ruwr_me,
   input  logic                      br_taken_ex,
   output logic                      stall_fd,
   output logic                      bubble_ex,
   output logic                      flush_fd,
   output logic [2*NUM_SRC-1:0]      fwd_sel_ex,
   output logic [STAT_W-1:0]         stat_stall,
   output logic [STAT_W-1:0]         stat_flush,
   output logic [STAT_W-1:0]         stat_fwd
);

   // The load-use cycle itself is the first stall cycle, so the STALL state
   // only covers the remaining LOAD_LAT-1 cycles (none when LOAD_LAT == 1).
   localparam int                 c_CNT_W     = (LOAD_LAT > 1) ? $clog2(LOAD_LAT) : 1;
   localparam bit                 c_HAS_STALL = (LOAD_LAT > 1);
   localparam logic [c_CNT_W-1:0] c_CNT_INIT  = c_CNT_W'(LOAD_LAT - 1);

   fwd_sel_e                 w_sel [NUM_SRC];
   logic [NUM_SRC-1:0]       w_hit;
   logic [2*NUM_SRC-1:0]     w_sel_flat;
   logic                     w_load_use;
   logic                     w_stall;
   logic                     w_flush;
   logic                     w_hold;
   haz_state_e               r_state;
   haz_state_e               w_state_nxt;
   logic [c_CNT_W-1:0]       r_cnt;
   logic [c_CNT_W-1:0]       w_cnt_nxt;
   logic [2*NUM_SRC-1:0]     r_fwd_sel;

   for (genvar gi = 0; gi < NUM_SRC; gi++) begin : g_src
      fwd_match #(
         .REG_AW (REG_AW)
      ) u_match (
         .rs         (rs_de[gi*REG_AW +: REG_AW]),
         .rs_used    (rs_used_de[gi]),
         .rd_ex      (rd_ex),
         .wr_ex      (ruwr_ex),
         .is_load_ex (is_load_ex),
         .rd_me      (rd_me),
         .wr_me      (ruwr_me),
         .sel        (w_sel[gi]),
         .load_hit   (w_hit[gi])
      );
      assign w_sel_flat[2*gi +: 2] = w_sel[gi];
   end

   assign w_load_use = |w_hit;

   // ---------------------------------------------------------------- state
   always_ff @(posedge clk) begin
      if (!rst_n) begin
         r_state <= RUN;
         r_cnt   <= '0;
      end else begin
         r_state <= w_state_nxt;
         r_cnt   <= w_cnt_nxt;
      end
   end

   // ----------------------------------------------------------- next state
   always_comb begin
      w_state_nxt = r_state;
      w_cnt_nxt   = r_cnt;
      if (br_taken_ex) begin
         w_state_nxt = RUN;
         w_cnt_nxt   = '0;
      end else begin
         case (r_state)
            RUN: begin
               if (w_load_use && c_HAS_STALL) begin
                  w_state_nxt = STALL;
                  w_cnt_nxt   = c_CNT_INIT;
               end
            end
            STALL: begin
               // r_cnt counts STALL cycles left including this one.
               if (r_cnt <= c_CNT_W'(1)) begin
                  w_state_nxt = RUN;
                  w_cnt_nxt   = '0;
               end else begin
                  w_cnt_nxt = r_cnt - c_CNT_W'(1);
               end
            end
            default: begin
               w_state_nxt = RUN;
               w_cnt_nxt   = '0;
            end
         endcase
      end
   end

   // -------------------------------------------------------------- outputs
   always_comb begin
      w_stall = 1'b0;
      w_flush = 1'b0;
      if (br_taken_ex) begin
         w_flush = 1'b1;
      end else if ((r_state == STALL) || w_load_use) begin
         w_stall = 1'b1;
      end
   end

   assign w_hold    = w_stall | w_flush;
   assign stall_fd  = rst_n & w_stall;
   assign flush_fd  = rst_n & w_flush;
   assign bubble_ex = rst_n & w_hold;

   // A bubble entering EX carries no operands, so its selects are RF.
   always_ff @(posedge clk) begin
      if (!rst_n) begin
         r_fwd_sel <= '0;
      end else if (w_hold) begin
         r_fwd_sel <= '0;
      end else begin
         r_fwd_sel <= w_sel_flat;
      end
   end

   assign fwd_sel_ex = r_fwd_sel;

   // ----------------------------------------------------------- statistics
`ifdef HAZ_STATS_EN
   logic [STAT_W-1:0] r_stat_stall;
   logic [STAT_W-1:0] r_stat_flush;
   logic [STAT_W-1:0] r_stat_fwd;
   logic [STAT_W-1:0] w_fwd_inc;
   logic [STAT_W:0]   w_fwd_sum;

   always_comb begin
      w_fwd_inc = '0;
      for (int i = 0; i < NUM_SRC; i++) begin
         if (w_sel[i] != SEL_RF) begin
            w_fwd_inc = w_fwd_inc + STAT_W'(1);
         end
      end
      if (w_hold) begin
         w_fwd_inc = '0;
      end
      w_fwd_sum = {1'b0, r_stat_fwd} + {1'b0, w_fwd_inc};
   end

   always_ff @(posedge clk) begin
      if (!rst_n) begin
         r_stat_stall <= '0;
         r_stat_flush <= '0;
         r_stat_fwd   <= '0;
      end else begin
         if (w_stall && (r_stat_stall != '1)) begin
            r_stat_stall <= r_stat_stall + STAT_W'(1);
         end
         if (w_flush && (r_stat_flush != '1)) begin
            r_stat_flush <= r_stat_flush + STAT_W'(1);
         end
         r_stat_fwd <= w_fwd_sum[STAT_W] ? '1 : w_fwd_sum[STAT_W-1:0];
      end
   end

   assign stat_stall = r_stat_stall;
   assign stat_flush = r_stat_flush;
   assign stat_fwd   = r_stat_fwd;
`else
   assign stat_stall = '0;
   assign stat_flush = '0;
   assign stat_fwd   = '0;
`endif

endmodule
`default_nettype wire

// File: tb/tb_hazard_fwd_unit.sv
`default_nettype none
// ============================================================================
//  Module      : tb_hazard_fwd_unit
//  Description : Directed bench for hazard_fwd_unit. Two instances share the
//                same stimulus: one with LOAD_LAT=1, one with LOAD_LAT=3.
//  Revision    : 1.0  initial release
// ============================================================================
module tb_hazard_fwd_unit;

`ifdef HAZ_STATS_EN
   localparam bit c_STATS = 1'b1;
`else
   localparam bit c_STATS = 1'b0;
`endif

   logic        clk = 1'b0;
   logic        rst_n = 1'b0;
   logic [9:0]  rs_de = '0;
   logic [1:0]  rs_used_de = '0;
   logic [4:0]  rd_ex = '0;
   logic        ruwr_ex = 1'b0;
   logic        is_load_ex = 1'b0;
   logic [4:0]  rd_me = '0;
   logic        ruwr_me = 1'b0;
   logic        br_taken_ex = 1'b0;

   logic        stall1, bub1, fl1;
   logic [3:0]  sel1;
   logic [31:0] ss1, sf1, sw1;
   logic        stall3, bub3, fl3;
   logic [3:0]  sel3;
   logic [31:0] ss3, sf3, sw3;

   always #5 clk = ~clk;

   hazard_fwd_unit #(.REG_AW(5), .NUM_SRC(2), .LOAD_LAT(1), .STAT_W(32)) u_dut1 (
      .clk(clk), .rst_n(rst_n), .rs_de(rs_de), .rs_used_de(rs_used_de),
      .rd_ex(rd_ex), .ruwr_ex(ruwr_ex), .is_load_ex(is_load_ex),
      .rd_me(rd_me), .ruwr_me(ruwr_me), .br_taken_ex(br_taken_ex),
      .stall_fd(stall1), .bubble_ex(bub1), .flush_fd(fl1), .fwd_sel_ex(sel1),
      .stat_stall(ss1), .stat_flush(sf1), .stat_fwd(sw1)
   );

   hazard_fwd_unit #(.REG_AW(5), .NUM_SRC(2), .LOAD_LAT(3), .STAT_W(32)) u_dut3 (
      .clk(clk), .rst_n(rst_n), .rs_de(rs_de), .rs_used_de(rs_used_de),
      .rd_ex(rd_ex), .ruwr_ex(ruwr_ex), .is_load_ex(is_load_ex),
      .rd_me(rd_me), .ruwr_me(ruwr_me), .br_taken_ex(br_taken_ex),
      .stall_fd(stall3), .bubble_ex(bub3), .flush_fd(fl3), .fwd_sel_ex(sel3),
      .stat_stall(ss3), .stat_flush(sf3), .stat_fwd(sw3)
   );

   typedef struct packed {
      logic [4:0] rs0;
      logic [4:0] rs1;
      logic [1:0] used;
      logic [4:0] dex;
      logic       wex;
      logic       ld;
      logic [4:0] dme;
      logic       wme;
      logic       exp_stall;
      logic [3:0] exp_sel;   // {src1, src0}
   } vec_t;

   vec_t vecs [11];

   int total = 0;
   int bad   = 0;
   int e1_stall = 0, e1_flush = 0, e1_fwd = 0;
   int e3_stall = 0, e3_flush = 0, e3_fwd = 0;

   task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
      total++;
      if (act !== exp) begin
         bad++;
         $display("FAIL %s actual=%0h expected=%0h", nm, act, exp);
      end
   endtask

   task automatic drive(input logic [4:0] r0, input logic [4:0] r1, input logic [1:0] u,
                        input logic [4:0] dex, input logic wex, input logic ld,
                        input logic [4:0] dme, input logic wme, input logic br);
      @(negedge clk);
      rs_de       = {r1, r0};
      rs_used_de  = u;
      rd_ex       = dex;
      ruwr_ex     = wex;
      is_load_ex  = ld;
      rd_me       = dme;
      ruwr_me     = wme;
      br_taken_ex = br;
      #1;
   endtask

   task automatic tick;
      @(posedge clk);
      #1;
   endtask

   function automatic int nonrf(input logic [3:0] s);
      return int'(s[1:0] != 2'b00) + int'(s[3:2] != 2'b00);
   endfunction

   task automatic chk_stats(input string tag);
      chk({tag, "_stall1"}, 64'(ss1), c_STATS ? 64'(e1_stall) : 64'd0);
      chk({tag, "_flush1"}, 64'(sf1), c_STATS ? 64'(e1_flush) : 64'd0);
      chk({tag, "_fwd1"},   64'(sw1), c_STATS ? 64'(e1_fwd)   : 64'd0);
      chk({tag, "_stall3"}, 64'(ss3), c_STATS ? 64'(e3_stall) : 64'd0);
      chk({tag, "_flush3"}, 64'(sf3), c_STATS ? 64'(e3_flush) : 64'd0);
      chk({tag, "_fwd3"},   64'(sw3), c_STATS ? 64'(e3_fwd)   : 64'd0);
   endtask

   initial begin
      #100000;
      $display("FAIL watchdog actual=timeout expected=finish");
      $fatal(1, "watchdog");
   end

   initial begin
      //           rs0    rs1    used   dex    wex   ld    dme    wme   stl   sel
      vecs[0]  = '{5'd3,  5'd10, 2'b11, 5'd3,  1'b1, 1'b0, 5'd10, 1'b1, 1'b0, 4'b1001};
      vecs[1]  = '{5'd5,  5'd6,  2'b11, 5'd5,  1'b1, 1'b0, 5'd5,  1'b1, 1'b0, 4'b0001};
      vecs[2]  = '{5'd0,  5'd0,  2'b11, 5'd0,  1'b1, 1'b0, 5'd0,  1'b1, 1'b0, 4'b0000};
      vecs[3]  = '{5'd3,  5'd3,  2'b11, 5'd3,  1'b0, 1'b0, 5'd3,  1'b1, 1'b0, 4'b1010};
      vecs[4]  = '{5'd4,  5'd9,  2'b00, 5'd4,  1'b1, 1'b0, 5'd9,  1'b1, 1'b0, 4'b0000};
      vecs[5]  = '{5'd7,  5'd2,  2'b10, 5'd7,  1'b1, 1'b1, 5'd2,  1'b1, 1'b0, 4'b1000};
      vecs[6]  = '{5'd31, 5'd31, 2'b11, 5'd31, 1'b1, 1'b0, 5'd0,  1'b0, 1'b0, 4'b0101};
      vecs[7]  = '{5'd8,  5'd9,  2'b11, 5'd1,  1'b1, 1'b0, 5'd2,  1'b1, 1'b0, 4'b0000};
      vecs[8]  = '{5'd6,  5'd8,  2'b11, 5'd7,  1'b1, 1'b1, 5'd8,  1'b1, 1'b0, 4'b1000};
      vecs[9]  = '{5'd7,  5'd4,  2'b01, 5'd7,  1'b0, 1'b1, 5'd7,  1'b1, 1'b0, 4'b0010};
      vecs[10] = '{5'd12, 5'd12, 2'b11, 5'd12, 1'b1, 1'b0, 5'd12, 1'b1, 1'b0, 4'b0101};

      // Reset: control outputs gated off even with load-use and branch present.
      rst_n = 1'b0;
      drive(5'd1, 5'd7, 2'b11, 5'd7, 1'b1, 1'b1, 5'd0, 1'b0, 1'b1);
      chk("rst_flush1", 64'(fl1), 64'd0);
      chk("rst_stall1", 64'(stall1), 64'd0);
      chk("rst_stall3", 64'(stall3), 64'd0);
      chk("rst_bub3", 64'(bub3), 64'd0);
      tick;
      chk("rst_sel1", 64'(sel1), 64'd0);
      chk("rst_sel3", 64'(sel3), 64'd0);
      chk_stats("rst");
      drive(5'd0, 5'd0, 2'b00, 5'd0, 1'b0, 1'b0, 5'd0, 1'b0, 1'b0);
      rst_n = 1'b1;
      tick;

      // Forwarding table.
      foreach (vecs[i]) begin
         drive(vecs[i].rs0, vecs[i].rs1, vecs[i].used, vecs[i].dex, vecs[i].wex,
               vecs[i].ld, vecs[i].dme, vecs[i].wme, 1'b0);
         chk($sformatf("v%0d_stall1", i), 64'(stall1), 64'(vecs[i].exp_stall));
         chk($sformatf("v%0d_stall3", i), 64'(stall3), 64'(vecs[i].exp_stall));
         tick;
         chk($sformatf("v%0d_sel1", i), 64'(sel1), 64'(vecs[i].exp_sel));
         chk($sformatf("v%0d_sel3", i), 64'(sel3), 64'(vecs[i].exp_sel));
         e1_fwd += nonrf(vecs[i].exp_sel);
         e3_fwd += nonrf(vecs[i].exp_sel);
      end

      // Load-use, no branch: LOAD_LAT=1 stalls 1 cycle, LOAD_LAT=3 stalls 3.
      drive(5'd1, 5'd7, 2'b11, 5'd7, 1'b1, 1'b1, 5'd0, 1'b0, 1'b0);
      chk("s1a_stall1", 64'(stall1), 64'd1);
      chk("s1a_bub1", 64'(bub1), 64'd1);
      chk("s1a_stall3", 64'(stall3), 64'd1);
      chk("s1a_flush1", 64'(fl1), 64'd0);
      e1_stall++; e3_stall++;
      tick;
      chk("s1a_sel1", 64'(sel1), 64'd0);
      chk("s1a_sel3", 64'(sel3), 64'd0);
      drive(5'd1, 5'd7, 2'b11, 5'd0, 1'b0, 1'b0, 5'd7, 1'b1, 1'b0);
      chk("s1b_stall1", 64'(stall1), 64'd0);
      chk("s1b_stall3", 64'(stall3), 64'd1);
      e3_stall++;
      tick;
      chk("s1b_sel1", 64'(sel1), 64'b1000);
      chk("s1b_sel3", 64'(sel3), 64'd0);
      e1_fwd++;
      drive(5'd1, 5'd7, 2'b11, 5'd0, 1'b0, 1'b0, 5'd0, 1'b0, 1'b0);
      chk("s1c_stall1", 64'(stall1), 64'd0);
      chk("s1c_stall3", 64'(stall3), 64'd1);
      e3_stall++;
      tick;
      chk("s1c_sel3", 64'(sel3), 64'd0);
      drive(5'd1, 5'd7, 2'b11, 5'd0, 1'b0, 1'b0, 5'd0, 1'b0, 1'b0);
      chk("s1d_stall3", 64'(stall3), 64'd0);
      tick;

      // Same hazard, branch in the third LOAD_LAT=3 stall cycle wins.
      drive(5'd1, 5'd7, 2'b11, 5'd7, 1'b1, 1'b1, 5'd0, 1'b0, 1'b0);
      chk("s2a_stall3", 64'(stall3), 64'd1);
      e1_stall++; e3_stall++;
      tick;
      drive(5'd1, 5'd7, 2'b11, 5'd0, 1'b0, 1'b0, 5'd7, 1'b1, 1'b0);
      chk("s2b_stall1", 64'(stall1), 64'd0);
      chk("s2b_stall3", 64'(stall3), 64'd1);
      e3_stall++;
      tick;
      chk("s2b_sel1", 64'(sel1), 64'b1000);
      e1_fwd++;
      drive(5'd1, 5'd7, 2'b11, 5'd0, 1'b0, 1'b0, 5'd0, 1'b0, 1'b1);
      chk("s2c_stall3", 64'(stall3), 64'd0);
      chk("s2c_flush3", 64'(fl3), 64'd1);
      chk("s2c_bub3", 64'(bub3), 64'd1);
      chk("s2c_flush1", 64'(fl1), 64'd1);
      chk("s2c_stall1", 64'(stall1), 64'd0);
      e1_flush++; e3_flush++;
      tick;
      chk("s2c_sel1", 64'(sel1), 64'd0);
      chk("s2c_sel3", 64'(sel3), 64'd0);
      drive(5'd0, 5'd0, 2'b00, 5'd0, 1'b0, 1'b0, 5'd0, 1'b0, 1'b0);
      chk("s2d_stall3", 64'(stall3), 64'd0);
      chk("s2d_flush3", 64'(fl3), 64'd0);
      tick;
      chk_stats("mid");

      // Reset in the middle of a LOAD_LAT=3 stall.
      drive(5'd1, 5'd7, 2'b11, 5'd7, 1'b1, 1'b1, 5'd0, 1'b0, 1'b0);
      chk("s4a_stall3", 64'(stall3), 64'd1);
      tick;
      drive(5'd1, 5'd7, 2'b11, 5'd0, 1'b0, 1'b0, 5'd7, 1'b1, 1'b0);
      rst_n = 1'b0;
      #1;
      chk("s4b_stall3", 64'(stall3), 64'd0);
      chk("s4b_bub3", 64'(bub3), 64'd0);
      chk("s4b_flush3", 64'(fl3), 64'd0);
      tick;
      chk("s4b_sel1", 64'(sel1), 64'd0);
      chk("s4b_sel3", 64'(sel3), 64'd0);
      e1_stall = 0; e1_flush = 0; e1_fwd = 0;
      e3_stall = 0; e3_flush = 0; e3_fwd = 0;
      chk_stats("post_rst");
      drive(5'd0, 5'd0, 2'b00, 5'd0, 1'b0, 1'b0, 5'd0, 1'b0, 1'b0);
      rst_n = 1'b1;
      #1;
      chk("s4c_stall3", 64'(stall3), 64'd0);
      chk("s4c_bub3", 64'(bub3), 64'd0);
      tick;
      drive(5'd0, 5'd0, 2'b00, 5'd0, 1'b0, 1'b0, 5'd0, 1'b0, 1'b0);
      chk("s4d_stall3", 64'(stall3), 64'd0);
      tick;

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
`default_nettype wire
